bus_arbiter: RTL and testbench



---
 rtl/pdp11_bus_pkg.sv | 17 +
 rtl/bus_arbiter_if.sv | 29 ++
 rtl/rr_pick.sv | 28 ++
 rtl/bus_arbiter.sv | 96 +++++++++
 tb/tb_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdp11_bus_pkg.sv
// Shared bus definitions: arbiter state encoding and default arbitration sizes.
package pdp11_bus_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_CPU  = 2'd1;
  localparam logic [1:0] ARB_DMA  = 2'd2;

  localparam int DEFAULT_NUM_DMA   = 4;
  localparam int DEFAULT_BURST_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_CPU  = ARB_CPU,
    ST_DMA  = ARB_DMA
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// RAM-port arbitration signals between the CPU/DMA requesters and the arbiter.
interface bus_arbiter_if #(
  parameter int NUM_DMA = 4,
  parameter int IDX_W   = 2
) ();

  logic               cpu_req;
  logic               cpu_arbitrate;
  logic               cpu_ack;
  logic               hold_en;
  logic               grant_cpu;
  logic [NUM_DMA-1:0] dma_req;
  logic [NUM_DMA-1:0] dma_ack;
  logic               grant_dma;
  logic [IDX_W-1:0]   grant_idx;

  // Requester side drives requests and observes grants.
  modport master (
    output cpu_req, cpu_arbitrate, dma_req,
    input  cpu_ack, hold_en, grant_cpu, dma_ack, grant_dma, grant_idx
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_arbitrate, dma_req,
    output cpu_ack, hold_en, grant_cpu, dma_ack, grant_dma, grant_idx
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit scanning upward from last+1, wrapping.
module rr_pick #(
  parameter int NUM_DMA = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_DMA-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] scan_pos;

  // Explicit compare for the wrap so non-power-of-two NUM_DMA works.
  always_comb begin
    any      = 1'b0;
    idx      = '0;
    scan_pos = last;
    for (int i = 0; i < NUM_DMA; i++) begin
      scan_pos = (scan_pos == IDX_W'(NUM_DMA - 1)) ? '0 : scan_pos + IDX_W'(1);
      if (!any && req[scan_pos]) begin
        any = 1'b1;
        idx = scan_pos;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared RAM port arbiter: 2-cycle CPU slots and round-robin DMA bursts,
// with a guaranteed CPU slot after every DMA burst.
module bus_arbiter
  import pdp11_bus_pkg::*;
#(
  parameter int NUM_DMA   = DEFAULT_NUM_DMA,
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int IDX_W     = 2
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] last_reg, last_next;
  logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic             cpu_first_reg, cpu_first_next;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NUM_DMA (NUM_DMA),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req  (bus.dma_req),
    .last (last_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      last_reg      <= IDX_W'(NUM_DMA - 1);
      burst_cnt_reg <= '0;
      cpu_first_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
      cpu_first_reg <= cpu_first_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    cpu_first_next = cpu_first_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_first_reg && bus.cpu_req) begin
          state_next     = ST_CPU;
          cpu_first_next = 1'b0;
        end else if (bus.cpu_arbitrate && pick_any) begin
          state_next     = ST_DMA;
          idx_next       = pick_idx;
          burst_cnt_next = CNT_W'(1);
        end else if (bus.cpu_req) begin
          state_next = ST_CPU;
        end
      end
      ST_CPU: state_next = ST_IDLE;
      ST_DMA: begin
        // Other masters are ignored until the current burst ends.
        if (bus.dma_req[idx_reg] && (burst_cnt_reg < CNT_W'(BURST_LEN))) begin
          burst_cnt_next = burst_cnt_reg + CNT_W'(1);
        end else begin
          state_next     = ST_IDLE;
          last_next      = idx_reg;
          cpu_first_next = bus.cpu_req;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.grant_cpu = (state_reg == ST_CPU);
  assign bus.grant_dma = (state_reg == ST_DMA);
  assign bus.hold_en   = (state_reg == ST_IDLE);
  assign bus.grant_idx = bus.grant_dma ? idx_reg : '0;
  assign bus.cpu_ack   = ~bus.cpu_req | bus.grant_cpu;

  for (genvar gi = 0; gi < NUM_DMA; gi++) begin : g_ack
    assign bus.dma_ack[gi] = bus.grant_dma && (idx_reg == IDX_W'(gi));
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NUM_DMA=4, BURST_LEN=4).
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_DMA(4), .IDX_W(2)) bus ();

  bus_arbiter #(.NUM_DMA(4), .BURST_LEN(4), .IDX_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_arbitrate = 1'b0;
    bus.dma_req = 4'b0000;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.hold_en !== 1'b1) begin failed++; $display("FAIL reset_hold_en got=%b exp=1", bus.hold_en); end
    tests++;
    if (bus.grant_cpu !== 1'b0) begin failed++; $display("FAIL reset_grant_cpu got=%b exp=0", bus.grant_cpu); end
    tests++;
    if (bus.dma_ack !== 4'b0000 || bus.grant_dma !== 1'b0 || bus.grant_idx !== 2'd0) begin
      failed++; $display("FAIL reset_dma got ack=%b gdma=%b idx=%0d exp 0000/0/0", bus.dma_ack, bus.grant_dma, bus.grant_idx);
    end
    tests++;
    if (bus.cpu_ack !== 1'b1) begin failed++; $display("FAIL reset_cpu_ack got=%b exp=1", bus.cpu_ack); end
    step();
    tests++;
    if (bus.hold_en !== 1'b1 || bus.dma_ack !== 4'b0000) begin
      failed++; $display("FAIL idle_stay got hold=%b ack=%b exp 1/0000", bus.hold_en, bus.dma_ack);
    end
    $display("[TB] reset/idle done");
  endtask

  task automatic test_cpu_access();
    bus.cpu_req = 1'b1;
    bus.cpu_arbitrate = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.cpu_ack !== 1'b0 || bus.hold_en !== 1'b1 || bus.grant_cpu !== 1'b0) begin
      failed++; $display("FAIL cpu_cycle1 got ack=%b hold=%b gcpu=%b exp 0/1/0", bus.cpu_ack, bus.hold_en, bus.grant_cpu);
    end
    step();
    @(negedge clk);
    tests++;
    if (bus.grant_cpu !== 1'b1 || bus.cpu_ack !== 1'b1 || bus.hold_en !== 1'b0) begin
      failed++; $display("FAIL cpu_cycle2 got gcpu=%b ack=%b hold=%b exp 1/1/0", bus.grant_cpu, bus.cpu_ack, bus.hold_en);
    end
    bus.cpu_req = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if (bus.grant_cpu !== 1'b0 || bus.hold_en !== 1'b1) begin
      failed++; $display("FAIL cpu_back_idle got gcpu=%b hold=%b exp 0/1", bus.grant_cpu, bus.hold_en);
    end
    step();
    $display("[TB] cpu access done");
  endtask

  task automatic test_burst_limit();
    bus.dma_req = 4'b0001;
    bus.cpu_arbitrate = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      tests++;
      if (bus.dma_ack !== 4'b0000 || bus.hold_en !== 1'b1) begin
        failed++; $display("FAIL burst%0d_idle got ack=%b hold=%b exp 0000/1", b, bus.dma_ack, bus.hold_en);
      end
      step();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        tests++;
        if (bus.dma_ack !== 4'b0001 || bus.grant_dma !== 1'b1 || bus.grant_idx !== 2'd0) begin
          failed++; $display("FAIL burst%0d_cyc%0d got ack=%b gdma=%b idx=%0d exp 0001/1/0", b, k, bus.dma_ack, bus.grant_dma, bus.grant_idx);
        end
        step();
      end
      $display("[TB] burst %0d of master 0 done", b);
    end
    bus.dma_req = 4'b0000;
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b0000 || bus.grant_dma !== 1'b0) begin
      failed++; $display("FAIL burst_end got ack=%b gdma=%b exp 0000/0", bus.dma_ack, bus.grant_dma);
    end
    step();
  endtask

  task automatic test_round_robin();
    int exp_w[4] = '{0, 1, 3, 0};
    logic [3:0] exp_ack;
    reset = 1'b1;
    bus.dma_req = 4'b0000;
    step();
    reset = 1'b0;
    bus.dma_req = 4'b1011;
    bus.cpu_arbitrate = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_ack = 4'b0001 << exp_w[b];
      step();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        tests++;
        if (bus.dma_ack !== exp_ack || bus.grant_idx !== 2'(exp_w[b])) begin
          failed++; $display("FAIL rr_burst%0d_cyc%0d got ack=%b idx=%0d exp %b/%0d", b, k, bus.dma_ack, bus.grant_idx, exp_ack, exp_w[b]);
        end
        step();
      end
      $display("[TB] rr burst %0d winner %0d", b, exp_w[b]);
    end
    bus.dma_req = 4'b0000;
    step();
  endtask

  task automatic test_starvation_guard();
    bus.dma_req = 4'b0001;
    bus.cpu_arbitrate = 1'b1;
    bus.cpu_req = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b0001) begin failed++; $display("FAIL starve_burst got ack=%b exp 0001", bus.dma_ack); end
    bus.cpu_req = 1'b1;
    #1;
    tests++;
    if (bus.cpu_ack !== 1'b0) begin failed++; $display("FAIL starve_cpu_wait got ack=%b exp 0", bus.cpu_ack); end
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    tests++;
    if (bus.hold_en !== 1'b1 || bus.dma_ack !== 4'b0000) begin
      failed++; $display("FAIL starve_idle got hold=%b ack=%b exp 1/0000", bus.hold_en, bus.dma_ack);
    end
    step();
    @(negedge clk);
    tests++;
    if (bus.grant_cpu !== 1'b1 || bus.dma_ack !== 4'b0000) begin
      failed++; $display("FAIL starve_cpu_slot got gcpu=%b ack=%b exp 1/0000", bus.grant_cpu, bus.dma_ack);
    end
    bus.cpu_req = 1'b0;
    step();
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b0001) begin failed++; $display("FAIL starve_dma_resume got ack=%b exp 0001", bus.dma_ack); end
    bus.dma_req = 4'b0000;
    step();
    @(negedge clk);
    tests++;
    if (bus.grant_dma !== 1'b0) begin failed++; $display("FAIL starve_drop got gdma=%b exp 0", bus.grant_dma); end
    step();
    $display("[TB] starvation guard done");
  endtask

  task automatic test_priority();
    // cpu_first is clear: CPU wins over DMA unless cpu_arbitrate is set.
    bus.cpu_req = 1'b1;
    bus.dma_req = 4'b0010;
    bus.cpu_arbitrate = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if (bus.grant_cpu !== 1'b1 || bus.grant_dma !== 1'b0) begin
      failed++; $display("FAIL prio_cpu got gcpu=%b gdma=%b exp 1/0", bus.grant_cpu, bus.grant_dma);
    end
    bus.cpu_arbitrate = 1'b1;
    step();
    step();
    @(negedge clk);
    tests++;
    if (bus.grant_dma !== 1'b1 || bus.dma_ack !== 4'b0010 || bus.grant_cpu !== 1'b0) begin
      failed++; $display("FAIL prio_dma got gdma=%b ack=%b gcpu=%b exp 1/0010/0", bus.grant_dma, bus.dma_ack, bus.grant_cpu);
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 4'b0000;
    step();
    step();
    $display("[TB] cpu/dma priority done");
  endtask

  task automatic test_early_release_reset();
    bus.dma_req = 4'b0100;
    bus.cpu_arbitrate = 1'b1;
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b0100) begin failed++; $display("FAIL early_cyc1 got ack=%b exp 0100", bus.dma_ack); end
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b0100 || bus.grant_idx !== 2'd2) begin
      failed++; $display("FAIL early_cyc2 got ack=%b idx=%0d exp 0100/2", bus.dma_ack, bus.grant_idx);
    end
    bus.dma_req = 4'b0000;
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b0000 || bus.hold_en !== 1'b1) begin
      failed++; $display("FAIL early_release got ack=%b hold=%b exp 0000/1", bus.dma_ack, bus.hold_en);
    end
    bus.dma_req = 4'b1111;
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b1000 || bus.grant_idx !== 2'd3) begin
      failed++; $display("FAIL after_last2 got ack=%b idx=%0d exp 1000/3", bus.dma_ack, bus.grant_idx);
    end
    bus.cpu_arbitrate = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b1000) begin failed++; $display("FAIL arb_drop_keeps got ack=%b exp 1000", bus.dma_ack); end
    reset = 1'b1;
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b0000 || bus.grant_dma !== 1'b0) begin
      failed++; $display("FAIL reset_mid_burst got ack=%b gdma=%b exp 0000/0", bus.dma_ack, bus.grant_dma);
    end
    reset = 1'b0;
    bus.cpu_arbitrate = 1'b1;
    step();
    @(negedge clk);
    tests++;
    if (bus.dma_ack !== 4'b0001 || bus.grant_idx !== 2'd0) begin
      failed++; $display("FAIL after_reset_last3 got ack=%b idx=%0d exp 0001/0", bus.dma_ack, bus.grant_idx);
    end
    bus.dma_req = 4'b0000;
    step();
    $display("[TB] early release and reset done");
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_arbitrate = 1'b0;
    bus.dma_req = 4'b0000;
    test_reset();
    test_cpu_access();
    test_burst_limit();
    test_round_robin();
    test_starvation_guard();
    test_priority();
    test_early_release_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
